bus_target_timer: RTL and testbench



---
 rtl/bus_target_timer.sv | 175 +++++++++++++++++
 tb/tb_bus_target_timer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_target_timer.sv
// Memory-mapped bus target with wait-state insertion, a 16-bit down-counter timer and a scratch register.
// Optional watchdog escalating an unserviced IRQ to NMI: define BUS_TARGET_WATCHDOG_EN.
module bus_target_timer #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] ADDRESS,
  input  logic        RW,
  input  logic [7:0]  CPU_DATA_OUT,
  output logic [7:0]  CPU_DATA_IN,
  output logic        RDY,
  output logic        IRQ,
  output logic        NMI
);

  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic [15:0] lat_addr;
  logic        lat_rw;
  logic        latch, cmpl, hold_rd, rdy_c;
  logic [2:0]  acc_off;
  logic        acc_rw;
  logic        hit, same, wr;
  logic [7:0]  rdata;

  logic [7:0]  reload_lo, reload_hi, scratch;
  logic [15:0] count;
  logic        en, irq_en, auto_rl, exp_q, irq_q, tick, w1c;

  assign hit  = (ADDRESS[15:3] == BASE_ADDR[15:3]);
  assign same = ({ADDRESS, RW} == {lat_addr, lat_rw});

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    latch     = 1'b0;
    cmpl      = 1'b0;
    hold_rd   = 1'b0;
    rdy_c     = 1'b1;
    acc_off   = ADDRESS[2:0];
    acc_rw    = RW;
    case (state)
      S_WAIT: begin
        acc_off = lat_addr[2:0];
        acc_rw  = lat_rw;
        if (!hit) begin
          // address left the window: drop the access without side effects
          rdy_c     = 1'b0;
          state_nxt = S_IDLE;
        end else if (wait_cnt == 4'd0) begin
          cmpl      = 1'b1;
          state_nxt = S_DONE;
        end else begin
          rdy_c    = 1'b0;
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      default: begin
        if (state == S_DONE && same) begin
          hold_rd = RW;
        end else if (hit) begin
          latch = 1'b1;
          if (WAIT_CYCLES > 0) begin
            rdy_c     = 1'b0;
            wait_nxt  = WAIT_INIT;
            state_nxt = S_WAIT;
          end else begin
            cmpl      = 1'b1;
            state_nxt = S_DONE;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      lat_addr <= 16'h0000;
      lat_rw   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (latch) begin
        lat_addr <= ADDRESS;
        lat_rw   <= RW;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (acc_off)
      3'd0: rdata = reload_lo;
      3'd1: rdata = reload_hi;
      3'd2: rdata = {5'b0, auto_rl, irq_en, en};
      3'd3: rdata = {7'b0, exp_q};
      3'd4: rdata = scratch;
      3'd5: rdata = count[7:0];
      3'd6: rdata = count[15:8];
      default: rdata = 8'h00;
    endcase
  end

  // Reset forces the bus idle even if ADDRESS still points into the window.
  assign RDY         = rdy_c | ~RST_N;
  assign CPU_DATA_IN = (RST_N && ((cmpl && acc_rw) || hold_rd)) ? rdata : 8'h00;

  assign wr   = cmpl & ~acc_rw;
  assign tick = en & (count == 16'h0000);
  assign w1c  = wr & (acc_off == 3'd3) & CPU_DATA_OUT[0];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      reload_lo <= 8'h00;
      reload_hi <= 8'h00;
      scratch   <= 8'h00;
      count     <= 16'h0000;
      en        <= 1'b0;
      irq_en    <= 1'b0;
      auto_rl   <= 1'b0;
      exp_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr && acc_off == 3'd0) reload_lo <= CPU_DATA_OUT;
      if (wr && acc_off == 3'd1) reload_hi <= CPU_DATA_OUT;
      if (wr && acc_off == 3'd4) scratch   <= CPU_DATA_OUT;
      if (wr && acc_off == 3'd2) {auto_rl, irq_en, en} <= CPU_DATA_OUT[2:0];
      else if (tick && !auto_rl) en <= 1'b0;
      if (tick)     exp_q <= 1'b1;
      else if (w1c) exp_q <= 1'b0;
      // a RELOAD_HI write takes precedence over counting
      if (wr && acc_off == 3'd1) count <= {CPU_DATA_OUT, reload_lo};
      else if (en) begin
        if (count != 16'h0000) count <= count - 16'h0001;
        else if (auto_rl)      count <= {reload_hi, reload_lo};
      end
      irq_q <= exp_q & irq_en;
    end
  end

  assign IRQ = irq_q;

`ifdef BUS_TARGET_WATCHDOG_EN
  logic [7:0] wd_cnt;
  logic       nmi_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wd_cnt <= 8'h00;
      nmi_q  <= 1'b0;
    end else begin
      // clearing on W1C too keeps the trailing IRQ cycle from re-arming NMI
      if (w1c || !irq_q)       wd_cnt <= 8'h00;
      else if (wd_cnt != 8'hFF) wd_cnt <= wd_cnt + 8'h01;
      if (w1c)                                nmi_q <= 1'b0;
      else if (irq_q && wd_cnt == 8'hFF)      nmi_q <= 1'b1;
    end
  end

  assign NMI = nmi_q;
`else
  assign NMI = 1'b0;
`endif

endmodule

// File: tb/tb_bus_target_timer.sv
// Directed bench for bus_target_timer with a cycle-level behavioural model checked every negedge.
module tb_bus_target_timer;
  localparam logic [15:0] BASE = 16'hD000;
  localparam int          W    = 2;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] ADDRESS = 16'h0000;
  logic        RW = 1'b1;
  logic [7:0]  CPU_DATA_OUT = 8'h00;
  logic [7:0]  CPU_DATA_IN;
  logic        RDY, IRQ, NMI;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bus_target_timer #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .ADDRESS(ADDRESS), .RW(RW),
    .CPU_DATA_OUT(CPU_DATA_OUT), .CPU_DATA_IN(CPU_DATA_IN),
    .RDY(RDY), .IRQ(IRQ), .NMI(NMI)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_rl = 0, m_rh = 0, m_scr = 0;
  logic [15:0] m_count = 0;
  logic        m_en = 0, m_ie = 0, m_auto = 0, m_exp = 0, m_irq = 0, m_nmi = 0;
  int          m_wd = 0;
  logic        m_act = 0, m_hv = 0;
  int          m_left = 0;
  logic [16:0] m_lkey = 0, m_hkey = 0;

  logic        e_rdy, do_wr, hitv, fire, w1c;
  logic [7:0]  e_dat, wv;
  logic [2:0]  off;
  logic [16:0] key;

  function automatic logic [7:0] mread(input logic [2:0] o);
    case (o)
      3'd0: return m_rl;
      3'd1: return m_rh;
      3'd2: return {5'b0, m_auto, m_ie, m_en};
      3'd3: return {7'b0, m_exp};
      3'd4: return m_scr;
      3'd5: return m_count[7:0];
      3'd6: return m_count[15:8];
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (!RST_N) begin
      m_rl = 0; m_rh = 0; m_scr = 0; m_count = 0;
      m_en = 0; m_ie = 0; m_auto = 0; m_exp = 0; m_irq = 0; m_nmi = 0; m_wd = 0;
      m_act = 0; m_hv = 0; m_left = 0;
      chk("rst_rdy", {15'b0, RDY}, 16'h1);
      chk("rst_data", {8'b0, CPU_DATA_IN}, 16'h0);
      chk("rst_irq", {15'b0, IRQ}, 16'h0);
      chk("rst_nmi", {15'b0, NMI}, 16'h0);
    end else begin
      key = {ADDRESS, RW};
      hitv = (ADDRESS[15:3] == BASE[15:3]);
      e_rdy = 1'b1; e_dat = 8'h00; do_wr = 1'b0; off = 3'd0;
      if (m_act) begin
        if (!hitv) begin
          e_rdy = 1'b0; m_act = 0;
        end else if (m_left > 0) begin
          e_rdy = 1'b0; m_left--;
        end else begin
          m_act = 0; m_hv = 1; m_hkey = m_lkey; off = m_lkey[3:1];
          if (m_lkey[0]) e_dat = mread(off); else do_wr = 1'b1;
        end
      end else if (m_hv && key == m_hkey) begin
        if (RW) e_dat = mread(ADDRESS[2:0]);
      end else begin
        m_hv = 0;
        if (hitv) begin
          if (W > 0) begin
            m_act = 1; m_left = W - 1; m_lkey = key; e_rdy = 1'b0;
          end else begin
            m_hv = 1; m_hkey = key; off = ADDRESS[2:0];
            if (RW) e_dat = mread(off); else do_wr = 1'b1;
          end
        end
      end
      chk("rdy", {15'b0, RDY}, {15'b0, e_rdy});
      chk("data", {8'b0, CPU_DATA_IN}, {8'b0, e_dat});
      chk("irq", {15'b0, IRQ}, {15'b0, m_irq});
      chk("nmi", {15'b0, NMI}, {15'b0, m_nmi});

      // state update at the coming edge, all from pre-edge values
      wv   = CPU_DATA_OUT;
      fire = m_en && (m_count == 0);
      w1c  = do_wr && off == 3'd3 && wv[0];
`ifdef BUS_TARGET_WATCHDOG_EN
      if (w1c) m_nmi = 0; else if (m_irq && m_wd == 255) m_nmi = 1;
      if (w1c || !m_irq) m_wd = 0; else if (m_wd < 255) m_wd++;
`endif
      m_irq = m_exp && m_ie;
      if (do_wr && off == 3'd1) m_count = {wv, m_rl};
      else if (m_en) m_count = (m_count != 0) ? m_count - 16'd1 : (m_auto ? {m_rh, m_rl} : 16'd0);
      if (fire) m_exp = 1; else if (w1c) m_exp = 0;
      if (do_wr && off == 3'd2) {m_auto, m_ie, m_en} = wv[2:0];
      else if (fire && !m_auto) m_en = 0;
      if (do_wr && off == 3'd0) m_rl = wv;
      if (do_wr && off == 3'd1) m_rh = wv;
      if (do_wr && off == 3'd4) m_scr = wv;
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic [15:0] a, input logic r, input logic [7:0] d, input int hold,
                     output logic [7:0] q, output int st);
    logic done;
    ADDRESS = a; RW = r; CPU_DATA_OUT = d; st = 0; q = 8'h00; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge CLK);
      if (RDY) begin q = CPU_DATA_IN; done = 1'b1; end
      else st++;
    end
    chk("acc_complete", {15'b0, done}, 16'h1);
    for (int i = 0; i < hold; i++) begin
      @(posedge CLK); #1; CPU_DATA_OUT = ~d;
    end
    @(posedge CLK); #1; ADDRESS = 16'h0000; RW = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] q; int st;
    acc(a, 1'b0, d, 0, q, st);
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] q);
    int st;
    acc(a, 1'b1, 8'h00, 0, q, st);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] q;
    int st, n;
    #1;
    chk("rst0_rdy", {15'b0, RDY}, 16'h1);
    chk("rst0_data", {8'b0, CPU_DATA_IN}, 16'h0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    idle(1);

    // reset in the middle of a stalled access
    wr(16'hD004, 8'hA5);
    ADDRESS = 16'hD004; RW = 1'b0; CPU_DATA_OUT = 8'h11;
    @(posedge CLK); #1;
    chk("midwait_stall", {15'b0, RDY}, 16'h0);
    #2 RST_N = 1'b0;
    #1;
    chk("midwait_rdy", {15'b0, RDY}, 16'h1);
    chk("midwait_irq", {15'b0, IRQ}, 16'h0);
    ADDRESS = 16'h0000; RW = 1'b1;
    @(posedge CLK); #1 RST_N = 1'b1;
    idle(1);
    rd(16'hD004, q);
    chk("midwait_scratch_cleared", {8'b0, q}, 16'h0000);

    // held write: one write only, stall count = W
    acc(16'hD004, 1'b0, 8'h5A, 4, q, st);
    chk("wr_stalls", st[15:0], 16'd2);
    acc(16'hD004, 1'b1, 8'h00, 0, q, st);
    chk("rd_stalls", st[15:0], 16'd2);
    chk("rd_scratch", {8'b0, q}, 16'h005A);

    // auto-reload timer
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h07);
    rd(16'hD005, q);
    chk("count_first_read", {8'b0, q}, 16'h0000);
    n = 0;
    while (!IRQ && n < 40) begin @(negedge CLK); n++; end
    chk("irq_rise", {15'b0, IRQ}, 16'h1);
    #1;
    rd(16'hD003, q);
    chk("exp_set", {8'b0, q}, 16'h0001);
    rd(16'hD000, q);
    chk("reload_lo_rb", {8'b0, q}, 16'h0003);
    rd(16'hD002, q);
    chk("ctrl_rb", {8'b0, q}, 16'h0007);
    wr(16'hD002, 8'h02);
    wr(16'hD003, 8'h01);
    idle(2);
    chk("irq_cleared", {15'b0, IRQ}, 16'h0);

    // one-shot timer
    wr(16'hD000, 8'h01);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    idle(10);
    rd(16'hD002, q);
    chk("oneshot_en_off", {8'b0, q}, 16'h0002);
    rd(16'hD005, q);
    chk("oneshot_count0", {8'b0, q}, 16'h0000);
    rd(16'hD003, q);
    chk("oneshot_exp", {8'b0, q}, 16'h0001);
    wr(16'hD003, 8'h01);
    idle(5);
    rd(16'hD003, q);
    chk("oneshot_no_reexp", {8'b0, q}, 16'h0000);
    chk("oneshot_irq_low", {15'b0, IRQ}, 16'h0);

    // W1C colliding with expiry (reload 0 + AUTO expires every cycle)
    wr(16'hD000, 8'h00);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h05);
    wr(16'hD003, 8'h01);
    rd(16'hD003, q);
    chk("w1c_vs_set", {8'b0, q}, 16'h0001);
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);
    rd(16'hD003, q);
    chk("w1c_after_stop", {8'b0, q}, 16'h0000);

    // abort: address leaves window mid-stall
    ADDRESS = 16'hD004; RW = 1'b0; CPU_DATA_OUT = 8'h77;
    @(posedge CLK); #1;
    ADDRESS = 16'h1234;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("abort_rdy", {15'b0, RDY}, 16'h1);
    @(posedge CLK); #1;
    ADDRESS = 16'h0000; RW = 1'b1;
    idle(1);
    rd(16'hD004, q);
    chk("abort_scratch", {8'b0, q}, 16'h005A);
    rd(16'hD007, q);
    chk("reserved_reads0", {8'b0, q}, 16'h0000);

`ifdef BUS_TARGET_WATCHDOG_EN
    wr(16'hD000, 8'h02);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    n = 0;
    while (!IRQ && n < 50) begin @(negedge CLK); n++; end
    chk("wd_irq", {15'b0, IRQ}, 16'h1);
    n = 0;
    while (!NMI && n < 300) begin @(negedge CLK); n++; end
    chk("wd_latency", n[15:0], 16'd256);
    #1;
    wr(16'hD003, 8'h01);
    idle(2);
    chk("wd_nmi_clear", {15'b0, NMI}, 16'h0);
`else
    chk("nmi_tied_low", {15'b0, NMI}, 16'h0);
`endif

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
